// File: rtl/lsu_pkg.sv
// Shared types for the LSU RAM port: funct3 size codes, FSM states, lane widths.
// No logic of its own; f3_size maps a funct3 code to an access width.
// Undefined funct3 codes decode as word accesses.
package lsu_pkg;

    localparam int LANE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = WORD_W / LANE_W;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RESP
    } state_e;

    function automatic size_e f3_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension of a RAM word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is sampled.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] ram_word,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [WORD_W-1:0] load_data
);

    logic [LANE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel  = LANE_W'(ram_word >> {offset, 3'b000});
        // Half selection ignores offset[0]; misaligned halves are trapped upstream when enabled.
        half_sel  = HALF_W'(ram_word >> {offset[1], 4'b0000});
        load_data = ram_word;
        case (f3_size(funct3))
            SZ_BYTE: load_data = funct3[2] ? {{(WORD_W-LANE_W){1'b0}}, byte_sel}
                                           : {{(WORD_W-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
            SZ_HALF: load_data = funct3[2] ? {{(WORD_W-HALF_W){1'b0}}, half_sel}
                                           : {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            default: load_data = ram_word;
        endcase
    end

endmodule

// File: rtl/lsu_ram_port.sv
// RV32I load/store port onto a 1-cycle registered RAM; LSU_MISALIGN_TRAP_EN enables misalignment faults.
// Latency: store/fault respond 1 enabled cycle after accept, loads 2 enabled cycles after accept.
// Backpressure: o_req_ready only in IDLE, so one request in flight; all state advances on i_clk_en.
module lsu_ram_port
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clk_en,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_misaligned,
    output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    output logic                  o_ram_write_en,
    output logic [3:0]            o_ram_byte_en,
    output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
    output logic [DATA_WIDTH-1:0] o_ram_write_data
);

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              f3_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    accept;
    logic                    req_fault;

    assign accept = (state_q == ST_IDLE) && i_req_valid && i_clk_en;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    always_comb begin
        req_fault = 1'b0;
        case (f3_size(i_req_funct3))
            SZ_HALF: req_fault = i_req_addr[0];
            SZ_WORD: req_fault = |i_req_addr[1:0];
            default: req_fault = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= req_fault;
        end
    end

    assign o_misaligned = mis_q;
`else
    assign req_fault    = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept) state_d = (i_req_we || req_fault) ? ST_RESP : ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (i_clk_en) state_d = ST_RESP;
            ST_RESP:      if (i_clk_en) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready     = (state_q == ST_IDLE);
        o_resp_valid    = (state_q == ST_RESP);
        // The write strobe only fires on the edge that also accepts the request.
        o_ram_write_en  = (state_q == ST_IDLE) && i_req_valid && i_req_we && !req_fault && i_clk_en;
        o_ram_read_addr = (state_q == ST_IDLE) ? (i_req_addr >> 2) : (addr_q >> 2);
    end

    always_comb begin
        o_ram_write_addr = i_req_addr >> 2;
        o_ram_byte_en    = 4'b1111;
        o_ram_write_data = i_req_wdata;
        case (f3_size(i_req_funct3))
            SZ_BYTE: begin
                o_ram_byte_en    = 4'b0001 << i_req_addr[1:0];
                o_ram_write_data = {NUM_LANES{i_req_wdata[LANE_W-1:0]}};
            end
            SZ_HALF: begin
                o_ram_byte_en    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                o_ram_write_data = {2{i_req_wdata[HALF_W-1:0]}};
            end
            default: begin
                o_ram_byte_en    = 4'b1111;
                o_ram_write_data = i_req_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= i_req_addr;
            f3_q    <= i_req_funct3;
            rdata_q <= '0;
        end else if ((state_q == ST_LOAD_WAIT) && i_clk_en) begin
            rdata_q <= load_data;
        end
    end

    assign o_resp_rdata = rdata_q;

    lsu_load_align u_load_align (
        .ram_word  (i_ram_read_data),
        .offset    (addr_q[1:0]),
        .funct3    (f3_q),
        .load_data (load_data)
    );

endmodule

// File: tb/tb_lsu_ram_port.sv
// Self-checking bench for lsu_ram_port with a behavioural 1-cycle RAM and a response scoreboard.
// Honours LSU_MISALIGN_TRAP_EN when choosing expected misalignment behaviour.
module tb_lsu_ram_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misaligned;
    logic [31:0] ram_raddr;
    logic [31:0] ram_rdata;
    logic        ram_wen;
    logic [3:0]  ram_be;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        s_wen;
    logic [3:0]  s_be;
    logic [31:0] s_wa;
    logic [31:0] s_wd;
    logic [31:0] s_ra;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    lsu_ram_port dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_clk_en         (clk_en),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_we         (req_we),
        .i_req_funct3     (req_f3),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_misaligned     (misaligned),
        .o_ram_read_addr  (ram_raddr),
        .i_ram_read_data  (ram_rdata),
        .o_ram_write_en   (ram_wen),
        .o_ram_byte_en    (ram_be),
        .o_ram_write_addr (ram_waddr),
        .o_ram_write_data (ram_wdata)
    );

    always @(posedge clk) begin
        if (ram_wen)
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) mem[ram_waddr[5:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
        ram_rdata <= mem[ram_raddr[5:0]];
    end

    // Presents a request, records the write/read port just before the accept edge, queues the expectation.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] erd, input logic emis, input int elat);
        int n = 0;
        req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout ready=%b required=1", req_ready);
        end
        s_wen = ram_wen; s_be = ram_be; s_wa = ram_waddr; s_wd = ram_wdata; s_ra = ram_raddr;
        exp_q.push_back('{erd, emis, elat});
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] rd, output logic mis, output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata; mis = misaligned;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] erd, input logic emis, input int elat,
                        output logic [40:0] got, output logic [40:0] expv);
        logic [31:0] rd;
        logic        mis;
        int          lat;
        exp_t        e;
        issue(we, f3, addr, wd, erd, emis, elat);
        get_resp(rd, mis, lat);
        e = exp_q.pop_front();
        got  = {rd, mis, lat[7:0]};
        expv = {e.rdata, e.mis, e.lat[7:0]};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, misaligned, ram_wen} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state ready=%b valid=%b rdata=%h mis=%b wen=%b required 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, misaligned, ram_wen);
        end
    endtask

    task automatic test_word();
        logic [40:0] got, expv;
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, got, expv);
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL sw_resp got=%h required=%h", got, expv); end
        n_checks++;
        if ({s_wen, s_be, s_wa, s_wd} !== {1'b1, 4'hF, 32'h4, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL sw_port got=%b %b %h %h required 1 1111 4 deadbeef", s_wen, s_be, s_wa, s_wd);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL resp_pulse valid=%b ready=%b required 0 1", resp_valid, req_ready);
        end
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, got, expv);
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL lw_resp got=%h required=%h", got, expv); end
        n_checks++;
        if ({s_wen, s_ra} !== {1'b0, 32'h4}) begin
            n_fail++; $display("FAIL lw_port wen=%b raddr=%h required 0 4", s_wen, s_ra);
        end
    endtask

    task automatic test_extend();
        logic [40:0] got, expv;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        xact(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 1, got, expv);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, f3s[i], adrs[i], 32'h0, exps[i], 1'b0, 2, got, expv);
            n_checks++;
            if (got !== expv) begin n_fail++; $display("FAIL extend_%0d got=%h required=%h", i, got, expv); end
        end
    endtask

    task automatic test_byte_store();
        logic [40:0] got, expv;
        xact(1'b1, 3'b010, 32'h04, 32'h11223344, 32'h0, 1'b0, 1, got, expv);
        xact(1'b1, 3'b000, 32'h05, 32'h556677AB, 32'h0, 1'b0, 1, got, expv);
        n_checks++;
        if ({s_wen, s_be, s_wa, s_wd} !== {1'b1, 4'b0010, 32'h1, 32'hABABABAB}) begin
            n_fail++; $display("FAIL sb_port got=%b %b %h %h required 1 0010 1 abababab", s_wen, s_be, s_wa, s_wd);
        end
        xact(1'b0, 3'b010, 32'h04, 32'h0, 32'h1122AB44, 1'b0, 2, got, expv);
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL sb_readback got=%h required=%h", got, expv); end
        xact(1'b1, 3'b010, 32'h0C, 32'h0, 32'h0, 1'b0, 1, got, expv);
        xact(1'b1, 3'b001, 32'h0E, 32'h1234BEEF, 32'h0, 1'b0, 1, got, expv);
        n_checks++;
        if ({s_wen, s_be, s_wa, s_wd} !== {1'b1, 4'b1100, 32'h3, 32'hBEEFBEEF}) begin
            n_fail++; $display("FAIL sh_port got=%b %b %h %h required 1 1100 3 beefbeef", s_wen, s_be, s_wa, s_wd);
        end
        xact(1'b0, 3'b010, 32'h0C, 32'h0, 32'hBEEF0000, 1'b0, 2, got, expv);
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL sh_readback got=%h required=%h", got, expv); end
    endtask

    task automatic test_misalign();
        logic [40:0] got, expv;
        xact(1'b1, 3'b010, 32'h18, 32'hCAFEF00D, 32'h0, 1'b0, 1, got, expv);
`ifdef LSU_MISALIGN_TRAP_EN
        xact(1'b0, 3'b010, 32'h1A, 32'h0, 32'h0, 1'b1, 1, got, expv);
`else
        xact(1'b0, 3'b010, 32'h1A, 32'h0, 32'hCAFEF00D, 1'b0, 2, got, expv);
`endif
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL mis_lw got=%h required=%h", got, expv); end
`ifdef LSU_MISALIGN_TRAP_EN
        xact(1'b0, 3'b001, 32'h19, 32'h0, 32'h0, 1'b1, 1, got, expv);
`else
        xact(1'b0, 3'b001, 32'h19, 32'h0, 32'hFFFFF00D, 1'b0, 2, got, expv);
`endif
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL mis_lh got=%h required=%h", got, expv); end
`ifdef LSU_MISALIGN_TRAP_EN
        xact(1'b1, 3'b010, 32'h1B, 32'h12345678, 32'h0, 1'b1, 1, got, expv);
        n_checks++;
        if (s_wen !== 1'b0) begin n_fail++; $display("FAIL mis_sw_strobe wen=%b required=0", s_wen); end
        xact(1'b0, 3'b010, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2, got, expv);
`else
        xact(1'b1, 3'b010, 32'h1B, 32'h12345678, 32'h0, 1'b0, 1, got, expv);
        n_checks++;
        if ({s_wen, s_be, s_wa} !== {1'b1, 4'hF, 32'h6}) begin
            n_fail++; $display("FAIL mis_sw_strobe got=%b %b %h required 1 1111 6", s_wen, s_be, s_wa);
        end
        xact(1'b0, 3'b010, 32'h18, 32'h0, 32'h12345678, 1'b0, 2, got, expv);
`endif
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL mis_readback got=%h required=%h", got, expv); end
    endtask

    task automatic test_undef_funct3();
        logic [40:0] got, expv;
        xact(1'b0, 3'b011, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 2, got, expv);
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL undef_load got=%h required=%h", got, expv); end
        xact(1'b1, 3'b110, 32'h24, 32'h01020304, 32'h0, 1'b0, 1, got, expv);
        n_checks++;
        if ({s_wen, s_be, s_wd} !== {1'b1, 4'hF, 32'h01020304}) begin
            n_fail++; $display("FAIL undef_store got=%b %b %h required 1 1111 01020304", s_wen, s_be, s_wd);
        end
    endtask

    task automatic test_clk_en();
        logic [31:0] rd;
        logic        mis;
        int          lat;
        exp_t        e;
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 2);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ram_raddr, resp_valid} !== {32'h8, 1'b0}) begin
                n_fail++; $display("FAIL stall_%0d raddr=%h valid=%b required 8 0", i, ram_raddr, resp_valid);
            end
        end
        clk_en = 1'b1;
        get_resp(rd, mis, lat);
        e = exp_q.pop_front();
        n_checks++;
        if ({rd, mis, lat[7:0]} !== {e.rdata, e.mis, e.lat[7:0]}) begin
            n_fail++; $display("FAIL stall_resp got=%h %b %0d required=%h %b %0d", rd, mis, lat, e.rdata, e.mis, e.lat);
        end
        @(posedge clk); #1;
        clk_en = 1'b0;
        req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h55AA55AA; req_valid = 1'b1;
        #1;
        n_checks++;
        if ({ram_wen, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL gated_strobe wen=%b ready=%b required 0 1", ram_wen, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL gated_hold ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        req_valid = 1'b0; req_we = 1'b0; clk_en = 1'b1;
    endtask

    task automatic test_reset_midload();
        int seen = 0;
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 2);
        void'(exp_q.pop_front());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready, resp_rdata} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rst_load valid=%b ready=%b rdata=%h required 0 1 0", resp_valid, req_ready, resp_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_no_resp pulses=%0d required=0", seen); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_byte_store();
        test_misalign();
        test_undef_funct3();
        test_clk_en();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ram_port.md
LSU_RAM_PORT -- requirements
Module: lsu_ram_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address and RAM-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock; i_rst  in  1  reset.
REQ-004 i_clk_en  in  1  clock enable; all state updates qualified by it.
REQ-005 i_req_valid  in  1  request present.
REQ-006 o_req_ready  out  1  accepting request.
REQ-007 i_req_we  in  1  1=store, 0=load.
REQ-008 i_req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 i_req_addr  in  ADDR_WIDTH  byte address.
REQ-010 i_req_wdata  in  32  store data, right-justified.
REQ-011 o_resp_valid  out  1  one-cycle completion pulse.
REQ-012 o_resp_rdata  out  32  aligned, extended load data; 0 for stores.
REQ-013 o_misaligned  out  1  completion is a misalignment fault; qualified by o_resp_valid.
REQ-014 o_ram_read_addr  out  ADDR_WIDTH  RAM word index = byte address >> 2.
REQ-015 i_ram_read_data  in  32  RAM registered read data, 1-cycle latency, ungated by clock enable.
REQ-016 o_ram_write_en, o_ram_byte_en[3:0], o_ram_write_addr[ADDR_WIDTH], o_ram_write_data[32]  out  RAM write port; byte lane k = bits 8k+7:8k.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-018 Accept = IDLE & i_req_valid & i_clk_en at a clock edge; no other state changes without i_clk_en.
REQ-019 In IDLE, o_ram_read_addr SHALL be combinationally i_req_addr >> 2; in LOAD_WAIT it SHALL hold the captured word index.
REQ-020 Store: write port driven combinationally in IDLE when i_req_valid & i_req_we & not faulted; write occurs on the accept edge; IDLE -> RESP.
REQ-021 Store lanes: SB byte_en = 1 << addr[1:0], data = byte replicated x4; SH byte_en = 0011 or 1100 by addr[1], data = half replicated x2; SW byte_en = 1111.
REQ-022 Load: IDLE -> LOAD_WAIT on accept; on next enabled edge capture i_ram_read_data, select lane by captured addr[1:0], zero-extend (BU/HU) or sign-extend (B/H) into o_resp_rdata; go to RESP.
REQ-023 o_resp_valid SHALL be 1 exactly while in RESP; RESP -> IDLE on next enabled edge.
REQ-024 Latency: store response 1 enabled cycle after accept; load response 2 enabled cycles after accept; throughput 1 request per 2 (store) / 3 (load) enabled cycles.
REQ-025 Undefined funct3 (011, 110, 111) SHALL be treated as word access.
REQ-026 o_ram_write_en SHALL be 0 in LOAD_WAIT and RESP and whenever i_clk_en = 0.

Reset
REQ-027 On i_rst: state IDLE, o_resp_valid 0, o_resp_rdata 0, o_misaligned 0, captured address/size 0; reset dominates i_clk_en.
REQ-028 Reset in LOAD_WAIT or RESP SHALL drop the transaction with no response; a store already written is not undone.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN: when defined, H/HU/SH with addr[0] = 1 or W/SW with addr[1:0] != 0 SHALL suppress the RAM write, go IDLE -> RESP, and return o_misaligned = 1, o_resp_rdata = 0.
REQ-030 Without LSU_MISALIGN_TRAP_EN, o_misaligned SHALL be tied 0 and the offending low address bits ignored (H uses addr[1] only, W uses neither).

Structure
REQ-031 Package lsu_pkg SHALL hold the funct3 size enum, the FSM state enum and the lane-select/extend width constants.
REQ-032 Sub-module lsu_load_align (combinational lane select + extension) SHALL be the only child instance.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> write byte_en 1111, addr 4; load response 0xDEADBEEF two enabled cycles after accept.
REQ-034 Word 0x80FF7F01 @0x20; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
REQ-035 SB 0xAB @0x05 -> byte_en 0010, write_data 0xABABABAB; later LW @0x04 shows only byte 1 changed.
REQ-036 With macro, LW @0x06 -> o_misaligned 1, rdata 0, no write strobe; without macro, same request -> word from addr 4, o_misaligned 0.
REQ-037 i_clk_en low for 3 cycles in LOAD_WAIT -> o_ram_read_addr stable, response still correct; i_rst asserted in LOAD_WAIT -> no o_resp_valid, o_req_ready 1 next cycle.
